// File: rtl/gray_dec_pkg.sv
// Shared types and helpers for the bit-serial Gray-to-binary decoder.
// Holds the FSM state encoding, default sizing and a popcount helper.
package gray_dec_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_ERR_CNT_W = 8;
    localparam int MAX_WIDTH         = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Callers zero-extend their WIDTH-bit word into the MAX_WIDTH argument.
    function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] word);
        int unsigned count;
        count = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            count = count + 32'(word[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// Tracks the previously accepted code word, flags words that are not exactly
// one bit away from it, and keeps a saturating count of those violations.
module gray_adj_checker
    import gray_dec_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 accept,
    input  logic [WIDTH-1:0]     in_code,
    input  logic                 hold_enter,
    output logic                 adj_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic [WIDTH-1:0]     prev_code_q, prev_code_d;
    logic                 prev_valid_q, prev_valid_d;
    logic                 adj_err_q, adj_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [MAX_WIDTH-1:0] diff_ext;
    logic                 step_ok;

    always_comb begin
        prev_code_d  = prev_code_q;
        prev_valid_d = prev_valid_q;
        adj_err_d    = adj_err_q;
        err_cnt_d    = err_cnt_q;

        diff_ext              = '0;
        diff_ext[WIDTH-1:0]   = in_code ^ prev_code_q;
        step_ok               = (popcount(diff_ext) == 1);

        // A repeated identical word has zero differing bits and counts as an error.
        if (accept) begin
            adj_err_d    = prev_valid_q & ~step_ok;
            prev_code_d  = in_code;
            prev_valid_d = 1'b1;
        end

        if (hold_enter && adj_err_q && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_code_q  <= '0;
            prev_valid_q <= 1'b0;
            adj_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            prev_code_q  <= prev_code_d;
            prev_valid_q <= prev_valid_d;
            adj_err_q    <= adj_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign adj_err = adj_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/gray4_seq_decoder.sv
// Bit-serial Gray-to-binary decoder with valid/ready handshakes on both sides.
// Decodes MSB first, one bit per clock, and reports single-step violations.
module gray4_seq_decoder
    import gray_dec_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bin,
    output logic                 out_adj_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    // The extra index bit acts as an underflow flag once bit 0 has been decoded.
    localparam int IDX_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH:0]   bin_ext;
    logic             accept;
    logic             decode_done;
    logic             hold_enter;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign out_bin     = bin_q;
    assign accept      = in_valid & in_ready;
    assign bin_ext     = {1'b0, bin_q};
    assign decode_done = idx_q[IDX_W-1];
    assign hold_enter  = (state_q == DECODE) && decode_done;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        bin_d   = bin_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d     = in_code;
                    bin_d   = '0;
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (decode_done) begin
                    state_d = HOLD;
                end else begin
                    // The zero above the MSB makes b[MSB] = g[MSB] fall out naturally.
                    for (int i = 0; i < WIDTH; i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            bin_d[i] = g_q[i] ^ bin_ext[i+1];
                        end
                    end
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
        end
    end

    gray_adj_checker #(
        .WIDTH     (WIDTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_adj_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .in_code    (in_code),
        .hold_enter (hold_enter),
        .adj_err    (out_adj_err),
        .err_cnt    (err_cnt)
    );

endmodule

// File: tb/tb_gray4_seq_decoder.sv
// Scoreboard bench for gray4_seq_decoder: a default instance and a narrow
// error-counter instance share stimulus so saturation can be observed.
module tb_gray4_seq_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_code = 4'd0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_adj_err, busy;
    logic [3:0] out_bin;
    logic [7:0] err_cnt;

    logic       in_ready2, out_valid2, out_adj_err2, busy2;
    logic [3:0] out_bin2;
    logic [1:0] err_cnt2;

    typedef struct {
        logic [3:0] bin;
        logic       adj;
        int         err8;
        int         err2;
    } expect_t;

    expect_t    scoreboard[$];
    int         vectorsApplied = 0;
    int         miscompares = 0;

    logic [3:0] modelPrevCode;
    logic       modelPrevValid;
    int         modelErr8;
    int         modelErr2;

    gray4_seq_decoder #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_adj_err(out_adj_err), .err_cnt(err_cnt), .busy(busy)
    );

    gray4_seq_decoder #(.WIDTH(4), .ERR_CNT_W(2)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
        .out_bin(out_bin2), .out_adj_err(out_adj_err2), .err_cnt(err_cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference decode by search: the binary v whose Gray image v^(v>>1) equals g.
    function automatic logic [3:0] grayToBin(input logic [3:0] g);
        logic [3:0] v;
        grayToBin = 4'd0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            if ((v ^ (v >> 1)) == g) grayToBin = v;
        end
    endfunction

    function automatic int bitsDiffer(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = a ^ b;
        bitsDiffer = 0;
        for (int i = 0; i < 4; i++) bitsDiffer += int'(d[i]);
    endfunction

    task automatic modelReset();
        modelPrevCode  = 4'd0;
        modelPrevValid = 1'b0;
        modelErr8      = 0;
        modelErr2      = 0;
        scoreboard.delete();
    endtask

    task automatic modelAccept(input logic [3:0] code);
        expect_t e;
        e.adj = modelPrevValid && (bitsDiffer(code, modelPrevCode) != 1);
        if (e.adj) begin
            if (modelErr8 < 255) modelErr8++;
            if (modelErr2 < 3) modelErr2++;
        end
        e.bin  = grayToBin(code);
        e.err8 = modelErr8;
        e.err2 = modelErr2;
        modelPrevCode  = code;
        modelPrevValid = 1'b1;
        scoreboard.push_back(e);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(modelErr8));
        checkOutput({tag, "_err_cnt_narrow"}, 32'(err_cnt2), 32'(modelErr2));
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        modelReset();
        checkIdle("reset");
        checkOutput("reset_out_bin", 32'(out_bin), 0);
        checkOutput("reset_out_adj_err", 32'(out_adj_err), 0);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic [3:0] code, input int holdCycles);
        expect_t e;
        int      edges;
        edges = 0;
        while (!in_ready && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("in_ready_before_accept", 32'(in_ready), 1);
        in_code   = code;
        in_valid  = 1'b1;
        out_ready = (holdCycles == 0);
        @(posedge clk);
        modelAccept(code);
        #1;
        in_valid = 1'b0;
        in_code  = 4'($urandom);
        checkOutput("in_ready_drop", 32'(in_ready), 0);
        checkOutput("busy_decode", 32'(busy), 1);

        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 20);
        checkOutput("out_valid_latency", 32'(edges), 5);
        checkOutput("scoreboard_depth", 32'(scoreboard.size()), 1);
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput("out_bin", 32'(out_bin), 32'(e.bin));
            checkOutput("out_adj_err", 32'(out_adj_err), 32'(e.adj));
            checkOutput("err_cnt", 32'(err_cnt), 32'(e.err8));
            checkOutput("err_cnt_narrow", 32'(err_cnt2), 32'(e.err2));
            checkOutput("out_bin_narrow", 32'(out_bin2), 32'(e.bin));

            for (int k = 0; k < holdCycles; k++) begin
                @(posedge clk);
                #1;
                checkOutput("hold_out_valid", 32'(out_valid), 1);
                checkOutput("hold_out_bin", 32'(out_bin), 32'(e.bin));
                checkOutput("hold_in_ready", 32'(in_ready), 0);
                checkOutput("hold_err_cnt", 32'(err_cnt), 32'(e.err8));
            end
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkIdle("after_handshake");
    endtask

    task automatic abortMidDecode(input logic [3:0] code);
        in_code  = code;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        checkIdle("abort");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] graySeq [16];
        graySeq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        modelReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        $display("[TB] single word 0110");
        applyStimulus(4'b0110, 0);

        $display("[TB] full Gray sequence");
        doReset();
        foreach (graySeq[i]) applyStimulus(graySeq[i], 0);

        $display("[TB] non-adjacent and repeated words with back-pressure");
        doReset();
        applyStimulus(4'b0000, 0);
        applyStimulus(4'b0011, 6);
        applyStimulus(4'b0011, 0);

        $display("[TB] reset during decode");
        abortMidDecode(4'b0111);
        applyStimulus(4'b1111, 0);

        $display("[TB] error counter saturation");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 4'b0000 : 4'b0011, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
